// File: rtl/interrupt_request_unit_pkg.sv
// Shared constants for the interrupt request unit:
// default I/O register addresses and FSM state encodings.
package interrupt_request_unit_pkg;

    localparam logic [7:0] IMSK_ADDR_DEF = 8'h3B;
    localparam logic [7:0] IFLG_ADDR_DEF = 8'h3A;

    localparam logic [0:0] STATE_IRQ_IDLE   = 1'b0;
    localparam logic [0:0] STATE_IRQ_LOCKED = 1'b1;

endpackage

// File: rtl/interrupt_request_unit_if.sv
// CPU-side handshake and I/O strobe bundle of the interrupt unit.
// bus_data stays a plain inout on the unit because it is tristated.
interface interrupt_request_unit_if #(
    parameter int ADDR_WIDTH   = 16,
    parameter int I_ADDR_WIDTH = 10
);
    logic                    irq;
    logic [I_ADDR_WIDTH-1:0] vector;
    logic                    ack;
    logic [ADDR_WIDTH-1:0]   bus_addr;
    logic                    io_cs;
    logic                    io_we;
    logic                    io_oe;

    modport master (
        input  irq, vector,
        output ack, bus_addr, io_cs, io_we, io_oe
    );

    modport slave (
        output irq, vector,
        input  ack, bus_addr, io_cs, io_we, io_oe
    );
endinterface

// File: rtl/interrupt_request_unit_edge_sync.sv
// One interrupt line: 2-flop synchronizer plus rising-edge pulse.
module interrupt_request_unit_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_src,
    output logic o_edge
);
    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_src;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_edge = r_s2 & ~r_prev;
endmodule

// File: rtl/interrupt_request_unit.sv
// Interrupt responder: pending flags, mask, priority select and
// irq/vector handshake with the control unit.
module interrupt_request_unit
    import interrupt_request_unit_pkg::*;
#(
    parameter int         N_SOURCES     = 8,
    parameter int         DATA_WIDTH    = 8,
    parameter int         ADDR_WIDTH    = 16,
    parameter int         I_ADDR_WIDTH  = 10,
    parameter int         VECTOR_BASE   = 1,
    parameter int         VECTOR_STRIDE = 1,
    parameter logic [7:0] IMSK_ADDR     = IMSK_ADDR_DEF,
    parameter logic [7:0] IFLG_ADDR     = IFLG_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SOURCES-1:0]  src,
    input  logic                  global_ie,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    interrupt_request_unit_if.slave bus
);
    localparam int IDX_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;

    logic [N_SOURCES-1:0]    r_imsk;
    logic [N_SOURCES-1:0]    r_iflg;
    logic [0:0]              r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [I_ADDR_WIDTH-1:0] r_vector;

    logic [N_SOURCES-1:0]    w_edge;
    logic [N_SOURCES-1:0]    w_ready;
    logic [N_SOURCES-1:0]    w_ack_clr;
    logic [N_SOURCES-1:0]    w_w1c;
    logic [N_SOURCES-1:0]    w_iflg_nxt;
    logic [N_SOURCES-1:0]    w_wdata;
    logic [IDX_W-1:0]        w_win;
    logic [I_ADDR_WIDTH-1:0] w_vec;
    logic                    w_any;
    logic                    w_hit_imsk;
    logic                    w_hit_iflg;
    logic                    w_rd_en;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    for (genvar g = 0; g < N_SOURCES; g++) begin : g_sync
        interrupt_request_unit_edge_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .i_src  (src[g]),
            .o_edge (w_edge[g])
        );
    end

    // Upper address bits must be zero, so compare against the zero-extended address
    assign w_hit_imsk = bus.bus_addr == ADDR_WIDTH'(IMSK_ADDR);
    assign w_hit_iflg = bus.bus_addr == ADDR_WIDTH'(IFLG_ADDR);
    assign w_wdata    = bus_data[N_SOURCES-1:0];

    assign w_ready = r_iflg & r_imsk;
    assign w_any   = |w_ready;

    always_comb begin
        w_win = '0;
        for (int i = N_SOURCES - 1; i >= 0; i--) begin
            if (w_ready[i]) w_win = IDX_W'(i);
        end
    end

    assign w_vec = I_ADDR_WIDTH'(VECTOR_BASE)
                 + I_ADDR_WIDTH'(w_win) * I_ADDR_WIDTH'(VECTOR_STRIDE);

    // A new edge always wins so a same-cycle clear never loses an event
    always_comb begin
        w_ack_clr = '0;
        if (r_state == STATE_IRQ_LOCKED && bus.ack) w_ack_clr[r_idx] = 1'b1;
        w_w1c = '0;
        if (bus.io_cs && bus.io_we && w_hit_iflg) w_w1c = w_wdata;
        w_iflg_nxt = w_edge | (r_iflg & ~w_ack_clr & ~w_w1c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_imsk <= '0;
            r_iflg <= '0;
        end else begin
            r_iflg <= w_iflg_nxt;
            if (bus.io_cs && bus.io_we && w_hit_imsk) r_imsk <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= STATE_IRQ_IDLE;
            r_idx    <= '0;
            r_vector <= '0;
        end else begin
            unique case (r_state)
                STATE_IRQ_IDLE: begin
                    if (global_ie && w_any) begin
                        r_state  <= STATE_IRQ_LOCKED;
                        r_idx    <= w_win;
                        r_vector <= w_vec;
                    end
                end
                STATE_IRQ_LOCKED: begin
                    if (bus.ack) begin
                        r_state  <= STATE_IRQ_IDLE;
                        r_vector <= '0;
                    end
                end
                default: r_state <= STATE_IRQ_IDLE;
            endcase
        end
    end

    assign bus.irq    = r_state == STATE_IRQ_LOCKED;
    assign bus.vector = r_vector;

    assign w_rd_en   = bus.io_cs && bus.io_oe && (w_hit_imsk || w_hit_iflg);
    assign w_rd_data = w_hit_imsk ? DATA_WIDTH'(r_imsk) : DATA_WIDTH'(r_iflg);
    assign bus_data  = w_rd_en ? w_rd_data : {DATA_WIDTH{1'bz}};
endmodule
